// File: rtl/uart_rx_byte_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote around each data/stop sample).
module uart_rx_byte_fifo #(
  parameter UART_CLK_TICKS_PER_BIT = 5'd20,
  parameter UART_CLK_TICKS_WIDTH   = 3'd5,
  parameter FIFO_DEPTH_BASE2       = 4
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      uart_rx,
  output logic [7:0]                data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      rx_running,
  output logic                      frame_error,
  output logic                      overflow,
  output logic [FIFO_DEPTH_BASE2:0] fifo_count,
  output logic [2:0]                rx_state
);

  localparam int TW    = UART_CLK_TICKS_WIDTH;
  localparam int AW    = FIFO_DEPTH_BASE2;
  localparam int DEPTH = 1 << AW;

  localparam logic [TW-1:0] TICK_LAST = TW'(UART_CLK_TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(UART_CLK_TICKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      rx_sync;
  logic            rx_s;
  logic [TW-1:0]   tick;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            nominal_tick;
  logic            sample_fire;
  logic            sample_bit;
  logic            push;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            push_ok;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], uart_rx};
  end
  assign rx_s = rx_sync[1];

  assign nominal_tick = ((state == S_DATA) || (state == S_STOP)) && (tick == TICK_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one cycle after the nominal tick so rx_s at N+1 can join the vote.
  logic [1:0] rx_hist;
  logic       vote_pend;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_hist   <= 2'b11;
      vote_pend <= 1'b0;
    end else begin
      rx_hist   <= {rx_hist[0], rx_s};
      vote_pend <= nominal_tick;
    end
  end

  assign sample_fire = vote_pend;
  assign sample_bit  = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign sample_fire = nominal_tick;
  assign sample_bit  = rx_s;
`endif

  assign push = (state == S_STOP) && sample_fire && sample_bit;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tick        <= '0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          tick    <= '0;
          bit_cnt <= 3'd0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (tick == TICK_HALF) begin
            tick  <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_DATA: begin
          tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
          if (sample_fire) begin
            shreg   <= {sample_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
          if (sample_fire) begin
            if (sample_bit) begin
              state <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          tick <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_running = (state != S_IDLE);
  assign rx_state   = state;

  // Handshake: a byte transfers on a rising edge where data_valid && data_ready;
  // data_out/data_valid hold until that edge, and data_ready while empty is ignored.
  assign data_valid = (fifo_count != '0);
  assign full       = (fifo_count == (AW+1)'(DEPTH));
  assign pop        = data_valid && data_ready;
  assign push_ok    = push && (!full || pop);
  assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

endmodule
